instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of the request; equals pc while imem_req_valid=1.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_rsp_valid  input  1  instruction word is present on imem_rsp_data.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction is presented to the control/datapath.
REQ-010 instr  output  32  held instruction word.
REQ-011 opcode  output  6  instr[31:26], feeding the main control decoder.
REQ-012 pc_out  output  32  address of the held instruction.
REQ-013 instr_ready  input  1  datapath retires the held instruction this cycle; control inputs are sampled in the same cycle.
REQ-014 branch, zero, jump, jal, jr  input  1 each  resolved control and ALU flags for the retiring instruction.
REQ-015 branch_offset  input  32  sign-extended word offset for branches.
REQ-016 jr_target  input  32  register value for jr.
REQ-017 ra_wr_en  output  1  one-cycle link-register write strobe.
REQ-018 ra_wr_data  output  32  link value, pc+4.
REQ-019 misalign_err  output  1  sticky flag for a misaligned jr target.

Function
REQ-020 The block SHALL implement four states: IDLE, REQ, WAIT, HOLD.
REQ-021 IDLE SHALL last exactly one cycle after reset deassertion, then move to REQ.
REQ-022 REQ SHALL drive imem_req_valid=1 with imem_addr=pc, and move to WAIT on the cycle imem_req_ready=1.
REQ-023 WAIT SHALL capture imem_rsp_data into instr on imem_rsp_valid=1 and move to HOLD; imem_rsp_valid SHALL be ignored in every other state.
REQ-024 A response asserted in the same cycle as the request acceptance SHALL NOT be captured; minimum REQ-entry-to-instr_valid latency is 2 cycles.
REQ-025 HOLD SHALL drive instr_valid=1 with instr, opcode and pc_out stable until instr_ready=1.
REQ-026 On HOLD with instr_ready=1, the block SHALL load pc with next_pc and move to REQ; instr_valid SHALL fall in the next cycle.
REQ-027 next_pc priority, highest first: jr -> jr_target with bits[1:0] forced to 0; jump (jal implies jump) -> {pc_plus4[31:28], instr[25:0], 2'b00}; branch&&zero -> pc_plus4 + (branch_offset<<2); otherwise -> pc_plus4.
REQ-028 If several redirect inputs are set simultaneously, the priority in REQ-027 SHALL decide; branch without zero SHALL fall through to pc_plus4.
REQ-029 All address arithmetic SHALL be 32-bit modulo: pc 32'hFFFF_FFFC plus 4 wraps to 0, and negative offsets wrap likewise.
REQ-030 On retire with jal=1, ra_wr_en SHALL pulse for exactly that cycle with ra_wr_data = pc_out+4; otherwise ra_wr_en=0.
REQ-031 On retire with jr=1 and jr_target[1:0]!=0, misalign_err SHALL set and hold until reset.
REQ-032 instr_ready and control inputs outside HOLD SHALL have no effect.

Reset
REQ-033 While rst_n=0: state=IDLE, pc=RESET_PC, instr=0, imem_req_valid=0, instr_valid=0, ra_wr_en=0, ra_wr_data=0, misalign_err=0.
REQ-034 Reset asserted mid-transaction (REQ, WAIT or HOLD) SHALL abandon the outstanding fetch; a late imem_rsp_valid arriving after reset SHALL be ignored.

Verification
REQ-035 Sequential fetch: memory ready on every cycle, 1-cycle response, instr_ready=1 in HOLD -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high for one cycle per instruction.
REQ-036 Backpressure: imem_req_ready low 3 cycles, instr_ready low 5 cycles -> imem_addr and instr held stable throughout; no duplicate requests.
REQ-037 Branch at pc 0x10 with offset -2, branch=1, zero=1 -> next imem_addr 0x0C; same instruction with zero=0 -> 0x14.
REQ-038 jal at pc 0x2000_0040 with instr[25:0]=0x0000100 -> ra_wr_en pulse, ra_wr_data=0x2000_0044, next imem_addr 0x2000_0400; jr=1 with jr_target=0x123 in the same retire -> next imem_addr 0x120, misalign_err=1.
REQ-039 Wrap-around: RESET_PC=0xFFFF_FFFC, sequential retire -> next imem_addr 0x0000_0000.
REQ-040 rst_n pulsed low during WAIT, then rsp_valid asserted -> no capture, instr_valid=0, next request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with next-pc redirect logic
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jr_target,
    output logic        ra_wr_en,
    output logic [31:0] ra_wr_data,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        retire;

    assign pc_plus4 = pc + 32'd4;
    assign retire   = (state == HOLD) && instr_ready;

    // jr wins over jump/jal, which win over a taken branch
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (jump || jal) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instr        <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == WAIT) && imem_rsp_valid) begin
                instr <= imem_rsp_data;
            end
            if (retire) begin
                pc <= next_pc;
                if (jr && (jr_target[1:0] != 2'b00)) begin
                    misalign_err <= 1'b1;
                end
            end
        end
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign opcode     = instr[31:26];
    assign ra_wr_en   = retire && jal;
    // link value is only driven during the strobe so it reads zero in reset
    assign ra_wr_data = ra_wr_en ? pc_plus4 : 32'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed bench for instr_fetch against a transaction-level model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_ready, branch, zero, jump, jal, jr;
    logic [31:0] branch_offset, jr_target;

    logic        imem_req_valid, instr_valid, ra_wr_en, misalign_err;
    logic [31:0] imem_addr, instr, pc_out, ra_wr_data;
    logic [5:0]  opcode;

    logic        w_req_valid, w_instr_valid, w_ra_wr_en, w_misalign_err;
    logic [31:0] w_addr, w_instr, w_pc_out, w_ra_wr_data;
    logic [5:0]  w_opcode;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_addr(imem_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc_out(pc_out),
        .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump), .jal(jal), .jr(jr),
        .branch_offset(branch_offset), .jr_target(jr_target),
        .ra_wr_en(ra_wr_en), .ra_wr_data(ra_wr_data), .misalign_err(misalign_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_addr(w_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(w_instr_valid), .instr(w_instr), .opcode(w_opcode), .pc_out(w_pc_out),
        .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump), .jal(jal), .jr(jr),
        .branch_offset(branch_offset), .jr_target(jr_target),
        .ra_wr_en(w_ra_wr_en), .ra_wr_data(w_ra_wr_data), .misalign_err(w_misalign_err)
    );

    int checks = 0;
    int errors = 0;

    // model: fetch bookkeeping expressed as "boot cycle / fetch outstanding / word held"
    bit          m_boot, m_out, m_held, m_mis;
    logic [31:0] m_pc, m_instr;
    logic [31:0] addr_log[$];
    logic [31:0] waddr_log[$];
    int          hold_cnt, acc_cnt;
    logic        last_ra_en;
    logic [31:0] last_ra_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (jr) return jr_target & 32'hFFFF_FFFC;
        if (jump || jal) return (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        if (branch && zero) return p4 + branch_offset * 32'd4;
        return p4;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'd0; instr_ready = 0;
        branch = 0; zero = 0; jump = 0; jal = 0; jr = 0;
        branch_offset = 32'd0; jr_target = 32'd0;
    endtask

    // compare outputs against the model, advance the model across the next edge
    task automatic step();
        bit exp_req, exp_ra;
        #1;
        last_ra_en   = ra_wr_en;
        last_ra_data = ra_wr_data;
        if (!rst_n) begin
            chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_pc", pc_out, 32'd0);
            chk("rst_ra_en", {31'd0, ra_wr_en}, 32'd0);
            chk("rst_ra_data", ra_wr_data, 32'd0);
            chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
            m_boot = 1; m_out = 0; m_held = 0; m_mis = 0; m_pc = 32'd0; m_instr = 32'd0;
        end else begin
            exp_req = !m_boot && !m_out && !m_held;
            exp_ra  = m_held && instr_ready && jal;
            chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_held});
            if (m_held) begin
                chk("instr", instr, m_instr);
                chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
                chk("pc_out", pc_out, m_pc);
                hold_cnt++;
            end
            chk("ra_wr_en", {31'd0, ra_wr_en}, {31'd0, exp_ra});
            if (exp_ra) chk("ra_wr_data", ra_wr_data, m_pc + 32'd4);
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
            if (imem_req_valid) addr_log.push_back(imem_addr);
            if (w_req_valid) waddr_log.push_back(w_addr);

            if (m_boot) begin
                m_boot = 0;
            end else if (m_held) begin
                if (instr_ready) begin
                    if (jr && (jr_target[1:0] != 2'b00)) m_mis = 1;
                    m_pc   = model_next();
                    m_held = 0;
                end
            end else if (m_out) begin
                if (imem_rsp_valid) begin
                    m_instr = imem_rsp_data;
                    m_out   = 0;
                    m_held  = 1;
                end
            end else if (imem_req_ready) begin
                m_out = 1;
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic to_hold(input logic [31:0] data);
        int n;
        idle_inputs();
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = data;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk("to_hold_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic retire(input bit br, input bit z, input bit jl, input bit r,
                          input logic [31:0] off, input logic [31:0] tgt);
        idle_inputs();
        instr_ready = 1; branch = br; zero = z; jal = jl; jr = r;
        branch_offset = off; jr_target = tgt;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        step(); step();

        // sequential fetch, plus the wrap-around instance on identical stimulus
        rst_n = 1;
        addr_log.delete(); waddr_log.delete(); hold_cnt = 0;
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h8C01_0004; instr_ready = 1;
        repeat (10) step();
        chk("seq_count", addr_log.size(), 32'd3);
        chk("seq_addr0", addr_log[0], 32'h0);
        chk("seq_addr1", addr_log[1], 32'h4);
        chk("seq_addr2", addr_log[2], 32'h8);
        chk("seq_holds", hold_cnt, 32'd3);
        chk("wrap_addr0", waddr_log[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", waddr_log[1], 32'h0000_0000);

        // backpressure: memory stalls 3 cycles, datapath stalls 5 cycles
        idle_inputs();
        acc_cnt = 0;
        repeat (3) step();
        imem_req_ready = 1; step();
        step();
        imem_rsp_valid = 1; imem_rsp_data = 32'h2108_0001; step();
        idle_inputs();
        repeat (5) step();
        chk("bp_accepts", acc_cnt, 32'd1);
        chk("bp_holding", {31'd0, instr_valid}, 32'd1);
        retire(0, 0, 0, 0, 32'd0, 32'd0);

        // branch at 0x10, taken and not taken
        to_hold(32'h1000_0000); retire(0, 0, 0, 1, 32'd0, 32'h10);
        to_hold(32'h1000_FFFE); retire(1, 1, 0, 0, 32'hFFFF_FFFE, 32'd0);
        chk("br_taken", imem_addr, 32'h0000_000C);
        to_hold(32'h1000_0000); retire(0, 0, 0, 1, 32'd0, 32'h10);
        to_hold(32'h1000_FFFE); retire(1, 0, 0, 0, 32'hFFFF_FFFE, 32'd0);
        chk("br_not_taken", imem_addr, 32'h0000_0014);

        // jal, then jal+jr with a misaligned target
        to_hold(32'h0); retire(0, 0, 0, 1, 32'd0, 32'h2000_0040);
        to_hold(32'h0C00_0100); retire(0, 0, 1, 0, 32'd0, 32'd0);
        chk("jal_ra_en", {31'd0, last_ra_en}, 32'd1);
        chk("jal_ra_data", last_ra_data, 32'h2000_0044);
        chk("jal_target", imem_addr, 32'h2000_0400);
        to_hold(32'h0C00_0100); retire(0, 0, 1, 1, 32'd0, 32'h123);
        chk("jr_target", imem_addr, 32'h0000_0120);
        chk("jr_misalign", {31'd0, misalign_err}, 32'd1);

        // reset during WAIT followed by a late response
        rst_n = 0; step();
        rst_n = 1; step();
        imem_req_ready = 1; step();
        rst_n = 0; step();
        rst_n = 1; idle_inputs(); imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
        step(); step();
        chk("late_rsp_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_rsp_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("late_rsp_addr", imem_addr, 32'h0);

        // randomized traffic with occasional resets
        repeat (3000) begin
            rst_n          = ($urandom % 400) != 0;
            imem_req_ready = ($urandom % 3) != 0;
            imem_rsp_valid = $urandom % 2;
            imem_rsp_data  = $urandom;
            instr_ready    = ($urandom % 3) == 0;
            branch         = $urandom % 2;
            zero           = $urandom % 2;
            jump           = ($urandom % 6) == 0;
            jal            = ($urandom % 8) == 0;
            jr             = ($urandom % 8) == 0;
            branch_offset  = $urandom_range(0, 64) - 32;
            jr_target      = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 5) == 0) ? ($urandom % 4) : 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
